// File: rtl/i2c_slave_sync_mem.sv
// I2C slave bridging a pad wrapper to a register file, fully synchronous to Clk.
// SCL/SDA are oversampled; the slave supports write bursts, repeated-START random reads and NACK/STOP recovery.
module i2c_slave_sync_mem #(
  parameter logic [6:0]  DEVADDR       = 7'h50,
  parameter int unsigned MEMADDRLENGTH = 8,
  parameter int unsigned SYNCSTAGES    = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     SCL,
  input  logic                     SDA,
  output logic                     SDA_oe,
  output logic [MEMADDRLENGTH-1:0] MemAddress,
  output logic [7:0]               MemWriteData,
  output logic                     MemWrite,
  output logic                     MemRead,
  input  logic [7:0]               MemReadData,
  output logic                     Busy,
  output logic                     Selected
);

  typedef enum logic [2:0] {
    StIdle, StDevAddr, StAck, StPtr, StWData, StRData, StRDataAck, StWaitStop
  } state_e;

  localparam logic [MEMADDRLENGTH-1:0] AddrOne = 1;

  logic [SYNCSTAGES-1:0] scl_sync, sda_sync;
  logic                  scl_prev, sda_prev, scl_s, sda_s;
  logic                  scl_rise, scl_fall, start_det, stop_det;

  state_e     state, ack_next;
  logic [3:0] bit_cnt;
  logic [7:0] shift, rd_shift, rx_byte;
  logic       rd_load;
  logic       ack_phase;

  assign scl_s     = scl_sync[SYNCSTAGES-1];
  assign sda_s     = sda_sync[SYNCSTAGES-1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign start_det = scl_s & scl_prev & ~sda_s & sda_prev;
  assign stop_det  = scl_s & scl_prev & sda_s & ~sda_prev;
  assign rx_byte   = {shift[6:0], sda_s};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNCSTAGES-2:0], SCL};
      sda_sync <= {sda_sync[SYNCSTAGES-2:0], SDA};
      scl_prev <= scl_s;
      sda_prev <= sda_s;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= StIdle;
      ack_next     <= StIdle;
      bit_cnt      <= 4'd0;
      shift        <= 8'h00;
      rd_shift     <= 8'h00;
      rd_load      <= 1'b0;
      ack_phase    <= 1'b0;
      SDA_oe       <= 1'b0;
      MemAddress   <= '0;
      MemWriteData <= 8'h00;
      MemWrite     <= 1'b0;
      MemRead      <= 1'b0;
      Busy         <= 1'b0;
      Selected     <= 1'b0;
    end else begin
      MemWrite <= 1'b0;
      MemRead  <= 1'b0;
      rd_load  <= MemRead;
      if (rd_load) rd_shift <= MemReadData;
      // Post-write increment lands one Clk after the strobe so the write sees the old pointer.
      if (MemWrite) MemAddress <= MemAddress + AddrOne;

      if (start_det) begin
        state    <= StDevAddr;
        bit_cnt  <= 4'd0;
        Busy     <= 1'b1;
        Selected <= 1'b0;
        SDA_oe   <= 1'b0;
      end else if (stop_det) begin
        state    <= StIdle;
        bit_cnt  <= 4'd0;
        Busy     <= 1'b0;
        Selected <= 1'b0;
        SDA_oe   <= 1'b0;
      end else begin
        case (state)
          StIdle: ;
          StDevAddr, StPtr, StWData: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt   <= 4'd0;
                ack_phase <= 1'b0;
                if (state == StDevAddr) begin
                  if (rx_byte[7:1] == DEVADDR) begin
                    state    <= StAck;
                    ack_next <= rx_byte[0] ? StRData : StPtr;
                  end else begin
                    state <= StWaitStop;
                  end
                end else if (state == StPtr) begin
                  MemAddress <= rx_byte[MEMADDRLENGTH-1:0];
                  state      <= StAck;
                  ack_next   <= StWData;
                end else begin
                  MemWriteData <= rx_byte;
                  MemWrite     <= 1'b1;
                  state        <= StAck;
                  ack_next     <= StWData;
                end
              end
            end
          end
          StAck: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                SDA_oe    <= 1'b1;
                Selected  <= 1'b1;
                ack_phase <= 1'b1;
                if (ack_next == StRData) MemRead <= 1'b1;
              end else begin
                state <= ack_next;
                if (ack_next == StRData) begin
                  // First read bit goes out on the same fall that ends the ACK slot.
                  SDA_oe   <= ~rd_shift[7];
                  rd_shift <= {rd_shift[6:0], 1'b1};
                  bit_cnt  <= 4'd1;
                end else begin
                  SDA_oe  <= 1'b0;
                  bit_cnt <= 4'd0;
                end
              end
            end
          end
          StRData: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                SDA_oe    <= 1'b0;
                bit_cnt   <= 4'd0;
                ack_phase <= 1'b0;
                state     <= StRDataAck;
              end else begin
                SDA_oe   <= ~rd_shift[7];
                rd_shift <= {rd_shift[6:0], 1'b1};
                bit_cnt  <= bit_cnt + 4'd1;
              end
            end
          end
          StRDataAck: begin
            if (scl_rise) begin
              if (!sda_s) begin
                MemAddress <= MemAddress + AddrOne;
                MemRead    <= 1'b1;
                ack_phase  <= 1'b1;
              end else begin
                Selected <= 1'b0;
                state    <= StWaitStop;
              end
            end else if (scl_fall && ack_phase) begin
              SDA_oe   <= ~rd_shift[7];
              rd_shift <= {rd_shift[6:0], 1'b1};
              bit_cnt  <= 4'd1;
              state    <= StRData;
            end
          end
          StWaitStop: SDA_oe <= 1'b0;
          default:    state  <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_sync_mem.sv
// Bench for i2c_slave_sync_mem: bit-banged I2C master, two slaves on one bus, and memory models.
// Expected writes and read addresses go into queues and are popped as the slaves strobe.
module tb_i2c_slave_sync_mem;
  localparam int QP = 50;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic sda_bus;

  logic       oe_a, wr_a, rd_a, busy_a, sel_a;
  logic [7:0] addr_a, wdata_a, rdata_a;
  logic       oe_b, wr_b, rd_b, busy_b, sel_b;
  logic [3:0] addr_b;
  logic [7:0] wdata_b, rdata_b;

  logic [7:0] mem_a [256];
  wr_t        wq_a[$];
  wr_t        wq_b[$];
  logic [7:0] rq_a[$];
  wr_t        exp_w;
  logic [7:0] exp_r;
  int         n_pass = 0;
  int         n_total = 0;
  int         wr_count_a = 0;
  logic       oe_seen = 1'b0;

  assign sda_bus = sda_m & ~oe_a & ~oe_b;
  assign rdata_b = 8'h00;

  always #5 clk = ~clk;

  i2c_slave_sync_mem #(.DEVADDR(7'h50), .MEMADDRLENGTH(8), .SYNCSTAGES(2)) dut_a (
    .Clk(clk), .Reset(reset), .SCL(scl), .SDA(sda_bus), .SDA_oe(oe_a),
    .MemAddress(addr_a), .MemWriteData(wdata_a), .MemWrite(wr_a), .MemRead(rd_a),
    .MemReadData(rdata_a), .Busy(busy_a), .Selected(sel_a)
  );

  i2c_slave_sync_mem #(.DEVADDR(7'h52), .MEMADDRLENGTH(4), .SYNCSTAGES(3)) dut_b (
    .Clk(clk), .Reset(reset), .SCL(scl), .SDA(sda_bus), .SDA_oe(oe_b),
    .MemAddress(addr_b), .MemWriteData(wdata_b), .MemWrite(wr_b), .MemRead(rd_b),
    .MemReadData(rdata_b), .Busy(busy_b), .Selected(sel_b)
  );

  always @(posedge clk) if (rd_a) rdata_a <= mem_a[addr_a];

  always @(negedge clk) begin
    if (oe_a || oe_b) oe_seen = 1'b1;
    if (wr_a) begin
      wr_count_a++;
      n_total++;
      if (wq_a.size() == 0) begin
        $display("FAIL wr_a_unexpected got addr=%h data=%h", addr_a, wdata_a);
      end else begin
        exp_w = wq_a.pop_front();
        if ({addr_a, wdata_a} !== {exp_w.addr, exp_w.data})
          $display("FAIL wr_a got addr=%h data=%h want addr=%h data=%h",
                   addr_a, wdata_a, exp_w.addr, exp_w.data);
        else n_pass++;
      end
    end
    if (wr_b) begin
      n_total++;
      if (wq_b.size() == 0) begin
        $display("FAIL wr_b_unexpected got addr=%h data=%h", addr_b, wdata_b);
      end else begin
        exp_w = wq_b.pop_front();
        if ({4'h0, addr_b, wdata_b} !== {exp_w.addr, exp_w.data})
          $display("FAIL wr_b got addr=%h data=%h want addr=%h data=%h",
                   addr_b, wdata_b, exp_w.addr, exp_w.data);
        else n_pass++;
      end
    end
    if (rd_a) begin
      n_total++;
      if (rq_a.size() == 0) begin
        $display("FAIL rd_a_unexpected got addr=%h", addr_a);
      end else begin
        exp_r = rq_a.pop_front();
        if (addr_a !== exp_r) $display("FAIL rd_a got addr=%h want addr=%h", addr_a, exp_r);
        else n_pass++;
      end
    end
  end

  // Each call starts just after an SCL fall (or from idle) and ends on an SCL fall.
  task automatic bit_xfer(input logic b, output logic s);
    #QP sda_m = b;
    #QP scl = 1'b1;
    #QP s = sda_bus;
    #QP scl = 1'b0;
  endtask

  task automatic i2c_start();
    #QP sda_m = 1'b1;
    #QP scl = 1'b1;
    #QP sda_m = 1'b0;
    #QP scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #QP sda_m = 1'b0;
    #QP scl = 1'b1;
    #QP sda_m = 1'b1;
    #QP;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic master_ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(~master_ack, s);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_total += 7;
    if (oe_a !== 1'b0) $display("FAIL rst_oe got=%b want=0", oe_a); else n_pass++;
    if (addr_a !== 8'h00) $display("FAIL rst_addr got=%h want=00", addr_a); else n_pass++;
    if (wdata_a !== 8'h00) $display("FAIL rst_wdata got=%h want=00", wdata_a); else n_pass++;
    if (wr_a !== 1'b0) $display("FAIL rst_write got=%b want=0", wr_a); else n_pass++;
    if (rd_a !== 1'b0) $display("FAIL rst_read got=%b want=0", rd_a); else n_pass++;
    if (busy_a !== 1'b0) $display("FAIL rst_busy got=%b want=0", busy_a); else n_pass++;
    if (sel_a !== 1'b0) $display("FAIL rst_sel got=%b want=0", sel_a); else n_pass++;
    reset = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_write_burst();
    logic ack;
    wq_a.push_back('{addr: 8'h10, data: 8'h11});
    wq_a.push_back('{addr: 8'h11, data: 8'h22});
    i2c_start();
    n_total += 7;
    write_byte(8'hA0, ack);
    if (ack !== 1'b1) $display("FAIL wb_ack_dev got=%b want=1", ack); else n_pass++;
    if (busy_a !== 1'b1) $display("FAIL wb_busy got=%b want=1", busy_a); else n_pass++;
    write_byte(8'h10, ack);
    if (ack !== 1'b1) $display("FAIL wb_ack_ptr got=%b want=1", ack); else n_pass++;
    write_byte(8'h11, ack);
    if (ack !== 1'b1) $display("FAIL wb_ack_d0 got=%b want=1", ack); else n_pass++;
    write_byte(8'h22, ack);
    if (ack !== 1'b1) $display("FAIL wb_ack_d1 got=%b want=1", ack); else n_pass++;
    if (sel_a !== 1'b1) $display("FAIL wb_sel got=%b want=1", sel_a); else n_pass++;
    i2c_stop();
    if (busy_a !== 1'b0) $display("FAIL wb_busy_stop got=%b want=0", busy_a); else n_pass++;
    n_total += 2;
    if (addr_a !== 8'h12) $display("FAIL wb_final_addr got=%h want=12", addr_a); else n_pass++;
    if (wq_a.size() !== 0) $display("FAIL wb_pending got=%0d want=0", wq_a.size()); else n_pass++;
  endtask

  task automatic test_random_read();
    logic ack;
    logic [7:0] d;
    mem_a[8'h05] = 8'h5A;
    mem_a[8'h06] = 8'hC3;
    rq_a.push_back(8'h05);
    rq_a.push_back(8'h06);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h05, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    n_total += 7;
    if (ack !== 1'b1) $display("FAIL rr_ack_dev got=%b want=1", ack); else n_pass++;
    if (sel_a !== 1'b1) $display("FAIL rr_sel got=%b want=1", sel_a); else n_pass++;
    read_byte(d, 1'b1);
    if (d !== 8'h5A) $display("FAIL rr_byte0 got=%h want=5a", d); else n_pass++;
    read_byte(d, 1'b0);
    if (d !== 8'hC3) $display("FAIL rr_byte1 got=%h want=c3", d); else n_pass++;
    if (sel_a !== 1'b0) $display("FAIL rr_sel_nack got=%b want=0", sel_a); else n_pass++;
    i2c_stop();
    if (addr_a !== 8'h06) $display("FAIL rr_final_addr got=%h want=06", addr_a); else n_pass++;
    if (rq_a.size() !== 0) $display("FAIL rr_pending got=%0d want=0", rq_a.size()); else n_pass++;
  endtask

  task automatic test_addr_mismatch();
    logic ack;
    int wc;
    wc = wr_count_a;
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'hA2, ack);
    n_total += 6;
    if (ack !== 1'b0) $display("FAIL mm_ack got=%b want=0", ack); else n_pass++;
    if (busy_a !== 1'b1) $display("FAIL mm_busy got=%b want=1", busy_a); else n_pass++;
    write_byte(8'h33, ack);
    i2c_stop();
    if (oe_seen !== 1'b0) $display("FAIL mm_oe got=%b want=0", oe_seen); else n_pass++;
    if (wr_count_a !== wc) $display("FAIL mm_writes got=%0d want=%0d", wr_count_a, wc); else n_pass++;
    if (busy_a !== 1'b0) $display("FAIL mm_busy_stop got=%b want=0", busy_a); else n_pass++;
    if (sel_a !== 1'b0) $display("FAIL mm_sel got=%b want=0", sel_a); else n_pass++;
  endtask

  task automatic test_wrap();
    logic ack;
    wq_b.push_back('{addr: 8'h0F, data: 8'hAB});
    wq_b.push_back('{addr: 8'h00, data: 8'hCD});
    i2c_start();
    write_byte(8'hA4, ack);
    n_total += 3;
    if (ack !== 1'b1) $display("FAIL wrap_ack got=%b want=1", ack); else n_pass++;
    write_byte(8'h3F, ack);
    write_byte(8'hAB, ack);
    write_byte(8'hCD, ack);
    i2c_stop();
    if (addr_b !== 4'h1) $display("FAIL wrap_final_addr got=%h want=1", addr_b); else n_pass++;
    if (wq_b.size() !== 0) $display("FAIL wrap_pending got=%0d want=0", wq_b.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    bit   seen;
    mem_a[8'h40] = 8'h3C;
    rq_a.push_back(8'h40);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h40, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = oe_a;
    end
    n_total += 5;
    if (seen !== 1'b1) $display("FAIL rmr_drive got=%b want=1", seen); else n_pass++;
    reset = 1'b1;
    @(posedge clk);
    #1;
    if (oe_a !== 1'b0) $display("FAIL rmr_oe got=%b want=0", oe_a); else n_pass++;
    if (busy_a !== 1'b0) $display("FAIL rmr_busy got=%b want=0", busy_a); else n_pass++;
    if (sel_a !== 1'b0) $display("FAIL rmr_sel got=%b want=0", sel_a); else n_pass++;
    if (addr_a !== 8'h00) $display("FAIL rmr_addr got=%h want=00", addr_a); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    i2c_stop();
    wq_a.push_back('{addr: 8'h20, data: 8'h77});
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h20, ack);
    write_byte(8'h77, ack);
    n_total += 3;
    if (ack !== 1'b1) $display("FAIL rmr_next_ack got=%b want=1", ack); else n_pass++;
    i2c_stop();
    if (addr_a !== 8'h21) $display("FAIL rmr_next_addr got=%h want=21", addr_a); else n_pass++;
    if (wq_a.size() !== 0) $display("FAIL rmr_pending got=%0d want=0", wq_a.size()); else n_pass++;
  endtask

  task automatic test_stop_in_wdata();
    logic ack;
    logic s;
    int   wc;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h30, ack);
    wc = wr_count_a;
    bit_xfer(1'b1, s);
    bit_xfer(1'b0, s);
    bit_xfer(1'b1, s);
    bit_xfer(1'b0, s);
    i2c_stop();
    repeat (10) @(negedge clk);
    n_total += 3;
    if (wr_count_a !== wc) $display("FAIL siw_writes got=%0d want=%0d", wr_count_a, wc); else n_pass++;
    if (addr_a !== 8'h30) $display("FAIL siw_addr got=%h want=30", addr_a); else n_pass++;
    if (busy_a !== 1'b0) $display("FAIL siw_busy got=%b want=0", busy_a); else n_pass++;
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
    test_reset();
    test_write_burst();
    test_random_read();
    test_addr_mismatch();
    test_wrap();
    test_reset_mid_read();
    test_stop_in_wdata();
    repeat (20) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
